// File: rtl/req_queue_pkg.sv
// req_queue_pkg
//   Shared types and defaults for the request slot queue.
//   slot_state_t     : per-slot lifecycle FREE -> PENDING -> ISSUED -> FREE
//   RQ_DEFAULT_SLOTS : default slot count (matches the arbiter requester count)
package req_queue_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    ISSUED  = 2'd2
  } slot_state_t;

  localparam int RQ_DEFAULT_SLOTS = 4;

endpackage : req_queue_pkg

// File: rtl/oh_to_idx.sv
// oh_to_idx
//   One-hot to binary index encoder. Input is expected to carry at most one set
//   bit; an all-zero input encodes to index 0.
//   i_oh  : one-hot vector, N bits
//   o_idx : binary index of the set bit, W bits
module oh_to_idx #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_oh,
  output logic [W-1:0] o_idx
);

  // OR-reduction of the indices of the set bits; exact for a one-hot input.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_oh[i]) begin
        o_idx = o_idx | W'(i);
      end
    end
  end

endmodule : oh_to_idx

// File: rtl/req_slot_queue.sv
// req_slot_queue
//   Requester-side slot tracker in front of a shared L2/IO port. Holds up to
//   NUM_SLOTS outstanding requests, exposes pending slots to an external
//   round-robin arbiter, issues the granted slot downstream and frees a slot
//   when its response returns.
//   clk, rst        : clock, synchronous active-high reset
//   enq_*           : new request handshake (enq_ready_o = a FREE slot exists)
//   req_bitmap_o    : PENDING slots, to the arbiter
//   grant_oh_i      : one-hot grant from the arbiter
//   update_en_o     : issue fired this cycle, to the arbiter
//   issue_*         : granted request toward downstream (valid/ready)
//   resp_valid_i/id : response returning for a slot
//   free_count_o    : number of FREE slots
//   protocol_err_o  : sticky, response seen for a slot that was not ISSUED
module req_slot_queue
  import req_queue_pkg::*;
#(
  parameter  int NUM_SLOTS  = RQ_DEFAULT_SLOTS,
  parameter  int ADDR_WIDTH = 32,
  localparam int ID_WIDTH   = $clog2(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid_i,
  input  logic [ADDR_WIDTH-1:0] enq_addr_i,
  output logic                  enq_ready_o,
  output logic [NUM_SLOTS-1:0]  req_bitmap_o,
  output logic                  update_en_o,
  input  logic [NUM_SLOTS-1:0]  grant_oh_i,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [ADDR_WIDTH-1:0] issue_addr_o,
  output logic [ID_WIDTH-1:0]   issue_id_o,
  input  logic                  resp_valid_i,
  input  logic [ID_WIDTH-1:0]   resp_id_i,
  output logic [ID_WIDTH:0]     free_count_o,
  output logic                  protocol_err_o
);

  slot_state_t           r_state [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] r_addr  [NUM_SLOTS];
  logic                  r_err;

  logic [NUM_SLOTS-1:0]  w_free_vec;
  logic [NUM_SLOTS-1:0]  w_pend_vec;
  logic [NUM_SLOTS-1:0]  w_alloc_oh;
  logic [ID_WIDTH-1:0]   w_alloc_idx;
  logic [NUM_SLOTS-1:0]  w_grant_masked;
  logic [NUM_SLOTS-1:0]  w_grant_oh;
  logic [ID_WIDTH-1:0]   w_issue_id;
  logic                  w_enq_fire;
  logic                  w_issue_fire;
  logic                  w_resp_in_range;
  logic                  w_resp_hit;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_decode
    assign w_free_vec[gi] = (r_state[gi] == FREE);
    assign w_pend_vec[gi] = (r_state[gi] == PENDING);
  end

  // Allocation looks only at registered state, so a slot freed by a response
  // this cycle cannot be handed out until the following cycle.
  assign w_alloc_oh = w_free_vec & (~w_free_vec + NUM_SLOTS'(1));

  oh_to_idx #(.N(NUM_SLOTS), .W(ID_WIDTH)) u_alloc_enc (
    .i_oh  (w_alloc_oh),
    .o_idx (w_alloc_idx)
  );

  // Grants on non-PENDING slots are dropped; the lowest surviving bit is kept
  // so a malformed multi-bit grant still selects exactly one slot.
  assign w_grant_masked = grant_oh_i & w_pend_vec;
  assign w_grant_oh     = w_grant_masked & (~w_grant_masked + NUM_SLOTS'(1));

  oh_to_idx #(.N(NUM_SLOTS), .W(ID_WIDTH)) u_issue_enc (
    .i_oh  (w_grant_oh),
    .o_idx (w_issue_id)
  );

  assign w_enq_fire      = enq_valid_i & enq_ready_o;
  assign w_issue_fire    = issue_valid_o & issue_ready_i;
  assign w_resp_in_range = (int'(resp_id_i) < NUM_SLOTS);
  assign w_resp_hit      = resp_valid_i & w_resp_in_range &
                           (r_state[resp_id_i] == ISSUED);

  // The three transitions act on slots in distinct states (FREE, PENDING,
  // ISSUED), so they never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= FREE;
        r_addr[i]  <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (w_enq_fire) begin
        r_state[w_alloc_idx] <= PENDING;
        r_addr[w_alloc_idx]  <= enq_addr_i;
      end
      if (w_issue_fire) begin
        r_state[w_issue_id] <= ISSUED;
      end
      if (w_resp_hit) begin
        r_state[resp_id_i] <= FREE;
      end
      if (resp_valid_i && !w_resp_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    free_count_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_count_o = free_count_o + (ID_WIDTH+1)'(w_free_vec[i]);
    end
  end

  assign enq_ready_o    = |w_free_vec;
  assign req_bitmap_o   = w_pend_vec;
  assign issue_valid_o  = |w_grant_oh;
  assign issue_id_o     = w_issue_id;
  assign issue_addr_o   = r_addr[w_issue_id];
  assign update_en_o    = w_issue_fire;
  assign protocol_err_o = r_err;

endmodule : req_slot_queue

// File: tb/tb_req_slot_queue.sv
module tb_req_slot_queue;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_valid_i;
  logic [AW-1:0] enq_addr_i;
  logic          enq_ready_o;
  logic [NS-1:0] req_bitmap_o;
  logic          update_en_o;
  logic [NS-1:0] grant_oh_i;
  logic          issue_valid_o;
  logic          issue_ready_i;
  logic [AW-1:0] issue_addr_o;
  logic [IW-1:0] issue_id_o;
  logic          resp_valid_i;
  logic [IW-1:0] resp_id_i;
  logic [IW:0]   free_count_o;
  logic          protocol_err_o;

  logic [NS-1:0] junk;
  int            arb_ptr;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: slot states 0=free 1=pending 2=issued
  int            m_state [NS];
  logic [AW-1:0] m_addr  [NS];
  int            m_ptr;
  bit            m_err;

  always #5 clk = ~clk;

  req_slot_queue #(.NUM_SLOTS(NS), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enq_valid_i    (enq_valid_i),
    .enq_addr_i     (enq_addr_i),
    .enq_ready_o    (enq_ready_o),
    .req_bitmap_o   (req_bitmap_o),
    .update_en_o    (update_en_o),
    .grant_oh_i     (grant_oh_i),
    .issue_valid_o  (issue_valid_o),
    .issue_ready_i  (issue_ready_i),
    .issue_addr_o   (issue_addr_o),
    .issue_id_o     (issue_id_o),
    .resp_valid_i   (resp_valid_i),
    .resp_id_i      (resp_id_i),
    .free_count_o   (free_count_o),
    .protocol_err_o (protocol_err_o)
  );

  // Round-robin pick: first requester at or after ptr; -1 when none.
  function automatic int rr_pick(logic [NS-1:0] req, int ptr);
    for (int k = 0; k < NS; k++) begin
      int idx;
      idx = (ptr + k) % NS;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // Behavioural rr_arbiter stand-in, plus junk grant bits on non-requesting slots.
  always_comb begin
    int p;
    p = rr_pick(req_bitmap_o, arb_ptr);
    grant_oh_i = junk & ~req_bitmap_o;
    if (p >= 0) grant_oh_i[p] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) arb_ptr <= 0;
    else if (update_en_o) arb_ptr <= (int'(issue_id_o) + 1) % NS;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_state[i] = 0;
      m_addr[i]  = '0;
    end
    m_ptr = 0;
    m_err = 0;
  endtask

  function automatic logic [NS-1:0] pend_of();
    logic [NS-1:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) if (m_state[i] == 1) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int free_of();
    int c;
    c = 0;
    for (int i = 0; i < NS; i++) if (m_state[i] == 0) c++;
    return c;
  endfunction

  task automatic at_neg();
    logic [NS-1:0] e_pend;
    int            e_gid;
    @(negedge clk);
    e_pend = pend_of();
    e_gid  = rr_pick(e_pend, m_ptr);
    chk("enq_ready", 64'(enq_ready_o), 64'(free_of() > 0));
    chk("req_bitmap", 64'(req_bitmap_o), 64'(e_pend));
    chk("free_count", 64'(free_count_o), 64'(free_of()));
    chk("issue_valid", 64'(issue_valid_o), 64'(e_gid >= 0));
    chk("update_en", 64'(update_en_o), 64'((e_gid >= 0) && issue_ready_i));
    chk("protocol_err", 64'(protocol_err_o), 64'(m_err));
    if (e_gid >= 0) begin
      chk("issue_id", 64'(issue_id_o), 64'(e_gid));
      chk("issue_addr", 64'(issue_addr_o), 64'(m_addr[e_gid]));
    end
  endtask

  task automatic to_pos();
    int old [NS];
    int gid;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      old = m_state;
      gid = rr_pick(pend_of(), m_ptr);
      if (enq_valid_i) begin
        for (int i = 0; i < NS; i++) begin
          if (old[i] == 0) begin
            m_state[i] = 1;
            m_addr[i]  = enq_addr_i;
            break;
          end
        end
      end
      if (gid >= 0 && issue_ready_i) begin
        m_state[gid] = 2;
        m_ptr = (gid + 1) % NS;
      end
      if (resp_valid_i) begin
        if (old[resp_id_i] == 2) m_state[resp_id_i] = 0;
        else m_err = 1;
      end
    end
    #1;
  endtask

  task automatic tick();
    at_neg();
    to_pos();
  endtask

  initial begin
    rst = 1'b1; enq_valid_i = 0; enq_addr_i = '0; issue_ready_i = 0;
    resp_valid_i = 0; resp_id_i = '0; junk = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // 1. reset state
    at_neg();
    chk("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    chk("rst_free_count", 64'(free_count_o), 64'd4);
    chk("rst_bitmap", 64'(req_bitmap_o), 64'd0);
    chk("rst_err", 64'(protocol_err_o), 64'd0);
    to_pos();

    // 2. four back-to-back enqueues, issued in order
    issue_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      enq_valid_i = 1;
      enq_addr_i  = 32'h100 * (k + 1);
      at_neg();
      if (k >= 1) begin
        chk("b2b_issue_id", 64'(issue_id_o), 64'(k - 1));
        chk("b2b_issue_addr", 64'(issue_addr_o), 64'(32'h100 * k));
        chk("b2b_update_en", 64'(update_en_o), 64'd1);
      end
      to_pos();
    end
    enq_valid_i = 0;
    at_neg();
    chk("b2b_last_id", 64'(issue_id_o), 64'd3);
    chk("b2b_last_addr", 64'(issue_addr_o), 64'h400);
    chk("b2b_full_ready", 64'(enq_ready_o), 64'd0);
    to_pos();
    issue_ready_i = 0;

    // 3. slots 1 and 3 pending, downstream stalled then released
    resp_valid_i = 1; resp_id_i = 2'd1; tick();
    resp_id_i = 2'd3; tick();
    resp_valid_i = 0;
    enq_valid_i = 1; enq_addr_i = 32'h600; tick();
    enq_addr_i = 32'h700; tick();
    enq_valid_i = 0;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk("stall_valid", 64'(issue_valid_o), 64'd1);
      chk("stall_update", 64'(update_en_o), 64'd0);
      chk("stall_id", 64'(issue_id_o), 64'd1);
      chk("stall_addr", 64'(issue_addr_o), 64'h600);
      to_pos();
    end
    issue_ready_i = 1;
    at_neg();
    chk("release_id1", 64'(issue_id_o), 64'd1);
    to_pos();
    at_neg();
    chk("release_id3", 64'(issue_id_o), 64'd3);
    chk("release_addr3", 64'(issue_addr_o), 64'h700);
    to_pos();
    issue_ready_i = 0;

    // 4. response and enqueue in the same cycle while full
    resp_valid_i = 1; resp_id_i = 2'd2; enq_valid_i = 1; enq_addr_i = 32'h500;
    at_neg();
    chk("samecyc_ready0", 64'(enq_ready_o), 64'd0);
    to_pos();
    resp_valid_i = 0;
    at_neg();
    chk("samecyc_ready1", 64'(enq_ready_o), 64'd1);
    to_pos();
    enq_valid_i = 0;
    at_neg();
    chk("samecyc_bitmap", 64'(req_bitmap_o), 64'b0100);
    to_pos();

    // 5. response to a FREE slot
    resp_valid_i = 1; resp_id_i = 2'd0; tick();
    tick();
    resp_valid_i = 0;
    at_neg();
    chk("err_set", 64'(protocol_err_o), 64'd1);
    chk("err_free_count", 64'(free_count_o), 64'd1);
    to_pos();
    tick();
    at_neg();
    chk("err_sticky", 64'(protocol_err_o), 64'd1);
    to_pos();

    // 6. reset with three slots issued
    issue_ready_i = 1; tick();
    issue_ready_i = 0;
    rst = 1; tick();
    rst = 0;
    at_neg();
    chk("midrst_free", 64'(free_count_o), 64'd4);
    chk("midrst_bitmap", 64'(req_bitmap_o), 64'd0);
    chk("midrst_err", 64'(protocol_err_o), 64'd0);
    chk("midrst_valid", 64'(issue_valid_o), 64'd0);
    to_pos();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      enq_valid_i   = $urandom_range(0, 1);
      enq_addr_i    = $urandom;
      issue_ready_i = ($urandom_range(0, 3) != 0);
      resp_valid_i  = ($urandom_range(0, 2) == 0);
      resp_id_i     = IW'($urandom_range(0, NS - 1));
      junk          = NS'($urandom);
      tick();
    end
    rst = 0; enq_valid_i = 0; resp_valid_i = 0; junk = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_req_slot_queue
